// File: rtl/uart_tx_engine_if.sv
// Handshake and buffer-port bundle between the transmit control logic and uart_tx_engine.
// The engine is the slave of the control side; the master modport drives start/length and the RAM data.
interface uart_tx_engine_if;
  logic        start;
  logic [9:0]  length;
  logic        busy;
  logic        done;
  logic        buf_rd;
  logic [7:0]  buf_addr;
  logic [31:0] buf_data;
  logic        uart_txd;

  modport master (
    output start, length, buf_data,
    input  busy, done, buf_rd, buf_addr, uart_txd
  );

  modport slave (
    input  start, length, buf_data,
    output busy, done, buf_rd, buf_addr, uart_txd
  );
endinterface

// File: rtl/uart_tx_engine.sv
// Serial transmit engine: fetches 32-bit words from the transmit half of the UART buffer
// and sends `length` bytes as 8N1 frames, LSB first, then pulses done.
module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 16
) (
  input logic             clk,
  input logic             rst,
  uart_tx_engine_if.slave bus
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, START, DATA, STOP, FINISH} state_t;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [9:0]       remaining;
  logic [9:0]       byte_index;  // one bit wider than an address so it can reach 512
  logic [31:0]      word_q;
  logic [7:0]       shift_q;

  logic [9:0]       len_clamped;
  logic [9:0]       next_index;
  logic             bit_end;

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] sel);
    return w[{sel, 3'b000} +: 8];
  endfunction

  // NOTE: every signal written here gets a value on every path, so no latch can be inferred.
  always_comb begin
    len_clamped = (bus.length > 10'd512) ? 10'd512 : bus.length;
    next_index  = byte_index + 10'd1;
    bit_end     = (bit_cnt == BIT_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: datapath registers are reset along with control so no X can ever reach uart_txd.
      state        <= IDLE;
      bit_cnt      <= '0;
      bit_idx      <= '0;
      remaining    <= '0;
      byte_index   <= '0;
      word_q       <= '0;
      shift_q      <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.buf_rd   <= 1'b0;
      bus.buf_addr <= '0;
      bus.uart_txd <= 1'b1;
    end else begin
      bus.done   <= 1'b0;
      bus.buf_rd <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            remaining  <= len_clamped;
            byte_index <= '0;
            if (len_clamped == 10'd0) begin
              state    <= FINISH;
              bus.done <= 1'b1;
            end else begin
              state        <= FETCH;
              bus.busy     <= 1'b1;
              bus.buf_rd   <= 1'b1;
              bus.buf_addr <= '0;
            end
          end
        end

        FETCH: state <= WAIT;

        // RAM data is valid this cycle; load the first byte directly so the start bit follows at once.
        WAIT: begin
          word_q       <= bus.buf_data;
          shift_q      <= pick_byte(bus.buf_data, byte_index[1:0]);
          bus.uart_txd <= 1'b0;
          state        <= START;
        end

        START: begin
          if (bit_end) begin
            bit_cnt      <= '0;
            bit_idx      <= '0;
            bus.uart_txd <= shift_q[0];
            state        <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bus.uart_txd <= 1'b1;
              state        <= STOP;
            end else begin
              shift_q      <= shift_q >> 1;
              bus.uart_txd <= shift_q[1];
              bit_idx      <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_end) begin
            bit_cnt    <= '0;
            remaining  <= remaining - 10'd1;
            byte_index <= next_index;
            if (remaining == 10'd1) begin
              state    <= FINISH;
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
            end else if (next_index[1:0] == 2'd0) begin
              state        <= FETCH;
              bus.buf_rd   <= 1'b1;
              bus.buf_addr <= {1'b0, next_index[8:2]};
            end else begin
              state        <= START;
              shift_q      <= pick_byte(word_q, next_index[1:0]);
              bus.uart_txd <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        FINISH: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
